// File: rtl/bcd_timer_ud.sv
// Two-field BCD up/down timer (hi:lo) with run/pause FSM, load, manual adjust,
// wrap/overflow and countdown-complete detection. Advances on an external tick.
module bcd_timer_ud #(
    parameter int LO_MOD = 60,
    parameter int HI_MOD = 60
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic        tick,
    input  logic        mode_down,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        load,
    input  logic [15:0] set_bcd,
    input  logic        adj_inc,
    input  logic        adj_dec,
    input  logic        adj_sel,
    output logic [15:0] bcd,
    output logic        running,
    output logic        ovf_pulse,
    output logic        done_pulse,
    output logic        alarm
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    localparam logic [7:0] LO_MAX = {4'((LO_MOD - 1) / 10), 4'((LO_MOD - 1) % 10)};
    localparam logic [7:0] HI_MAX = {4'((HI_MOD - 1) / 10), 4'((HI_MOD - 1) % 10)};

    state_t     state_q, state_d;
    logic [7:0] lo_q, lo_d, hi_q, hi_d;
    logic       ovf_d, done_d;
    logic       is_zero, can_adjust;

    function automatic logic [7:0] fld_inc(input logic [7:0] v, input logic [7:0] max_v);
        logic [7:0] r;
        if (v == max_v)            r = 8'h00;
        else if (v[3:0] == 4'd9)   r = {v[7:4] + 4'd1, 4'd0};
        else                       r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic [7:0] fld_dec(input logic [7:0] v, input logic [7:0] max_v);
        logic [7:0] r;
        if (v == 8'h00)            r = max_v;
        else if (v[3:0] == 4'd0)   r = {v[7:4] - 4'd1, 4'd9};
        else                       r = {v[7:4], v[3:0] - 4'd1};
        return r;
    endfunction

    // With both digits legal, BCD bytes order like their decimal values,
    // so "field >= modulus" reduces to "field > max".
    function automatic logic [7:0] fld_legal(input logic [7:0] v, input logic [7:0] max_v);
        logic [7:0] r;
        if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v > max_v) r = max_v;
        else                                            r = v;
        return r;
    endfunction

    assign is_zero    = (hi_q == 8'h00) && (lo_q == 8'h00);
    assign can_adjust = (state_q == S_IDLE) || (state_q == S_PAUSE);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        ovf_d   = 1'b0;
        done_d  = 1'b0;

        if (clear) begin
            lo_d    = 8'h00;
            hi_d    = 8'h00;
            state_d = S_IDLE;
        end else if (load) begin
            if (state_q != S_RUN) begin
                lo_d = fld_legal(set_bcd[7:0], LO_MAX);
                hi_d = fld_legal(set_bcd[15:8], HI_MAX);
                if (state_q == S_DONE) state_d = S_IDLE;
            end
        end else if (start_stop) begin
            case (state_q)
                S_IDLE, S_PAUSE: if (!(mode_down && is_zero)) state_d = S_RUN;
                S_RUN:           state_d = S_PAUSE;
                default:         state_d = S_IDLE;
            endcase
        end else if ((adj_inc ^ adj_dec) && can_adjust) begin
            if (adj_sel) hi_d = adj_inc ? fld_inc(hi_q, HI_MAX) : fld_dec(hi_q, HI_MAX);
            else         lo_d = adj_inc ? fld_inc(lo_q, LO_MAX) : fld_dec(lo_q, LO_MAX);
        end else if (tick && state_q == S_RUN) begin
            if (mode_down) begin
                // A down tick at 00:00 holds the value and completes rather than wrapping.
                if (!is_zero) begin
                    if (lo_q == 8'h00) begin
                        lo_d = LO_MAX;
                        hi_d = fld_dec(hi_q, HI_MAX);
                    end else begin
                        lo_d = fld_dec(lo_q, LO_MAX);
                    end
                end
                if (hi_d == 8'h00 && lo_d == 8'h00) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end else begin
                lo_d = fld_inc(lo_q, LO_MAX);
                if (lo_q == LO_MAX) begin
                    hi_d  = fld_inc(hi_q, HI_MAX);
                    ovf_d = (hi_q == HI_MAX);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q    <= S_IDLE;
            lo_q       <= 8'h00;
            hi_q       <= 8'h00;
            running    <= 1'b0;
            ovf_pulse  <= 1'b0;
            done_pulse <= 1'b0;
            alarm      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            running    <= (state_d == S_RUN);
            ovf_pulse  <= ovf_d;
            done_pulse <= done_d;
            // Alarm follows DONE one cycle late and drops in the same cycle DONE exits.
            alarm      <= (state_q == S_DONE) && (state_d == S_DONE);
        end
    end

    assign bcd = {hi_q, lo_q};

endmodule

// File: tb/tb_bcd_timer_ud.sv
// Directed testbench for bcd_timer_ud: a 60:60 instance and a 100:100 instance
// share one stimulus set; each test checks the instance it targets.
module tb_bcd_timer_ud;

    logic        clk = 1'b0;
    logic        reset_p, tick, mode_down, start_stop, clear, load;
    logic        adj_inc, adj_dec, adj_sel;
    logic [15:0] set_bcd;

    logic [15:0] bcd60, bcd100;
    logic        run60, ovf60, done60, alarm60;
    logic        run100, ovf100, done100, alarm100;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bcd_timer_ud #(.LO_MOD(60), .HI_MOD(60)) dut60 (
        .clk(clk), .reset_p(reset_p), .tick(tick), .mode_down(mode_down),
        .start_stop(start_stop), .clear(clear), .load(load), .set_bcd(set_bcd),
        .adj_inc(adj_inc), .adj_dec(adj_dec), .adj_sel(adj_sel),
        .bcd(bcd60), .running(run60), .ovf_pulse(ovf60), .done_pulse(done60), .alarm(alarm60)
    );

    bcd_timer_ud #(.LO_MOD(100), .HI_MOD(100)) dut100 (
        .clk(clk), .reset_p(reset_p), .tick(tick), .mode_down(mode_down),
        .start_stop(start_stop), .clear(clear), .load(load), .set_bcd(set_bcd),
        .adj_inc(adj_inc), .adj_dec(adj_dec), .adj_sel(adj_sel),
        .bcd(bcd100), .running(run100), .ovf_pulse(ovf100), .done_pulse(done100), .alarm(alarm100)
    );

    // One clock edge; pulse inputs are released 1 ns after it, then outputs are stable to sample.
    task automatic step();
        @(posedge clk);
        #1;
        tick = 1'b0; start_stop = 1'b0; clear = 1'b0; load = 1'b0;
        adj_inc = 1'b0; adj_dec = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] v);
        set_bcd = v; load = 1'b1; step();
    endtask

    task automatic chk60(input string name, input logic [15:0] exp_bcd, input logic exp_run,
                         input logic exp_ovf, input logic exp_done, input logic exp_alarm);
        n_checks++;
        if ({bcd60, run60, ovf60, done60, alarm60} !== {exp_bcd, exp_run, exp_ovf, exp_done, exp_alarm}) begin
            n_fail++;
            $display("FAIL %s: got bcd=%h run=%b ovf=%b done=%b alarm=%b, expected bcd=%h run=%b ovf=%b done=%b alarm=%b",
                     name, bcd60, run60, ovf60, done60, alarm60, exp_bcd, exp_run, exp_ovf, exp_done, exp_alarm);
        end
    endtask

    task automatic test_reset();
        reset_p = 1'b0; tick = 1'b0; mode_down = 1'b0; start_stop = 1'b0; clear = 1'b0;
        load = 1'b0; adj_inc = 1'b0; adj_dec = 1'b0; adj_sel = 1'b0; set_bcd = 16'h0000;
        #1 reset_p = 1'b1;
        #1 chk60("reset_state", 16'h0000, 0, 0, 0, 0);
        #12 reset_p = 1'b0;
        step();
    endtask

    task automatic test_up_wrap();
        mode_down = 1'b0;
        do_load(16'h5958);
        chk60("up_load", 16'h5958, 0, 0, 0, 0);
        start_stop = 1'b1; step();
        chk60("up_start", 16'h5958, 1, 0, 0, 0);
        tick = 1'b1; step();
        chk60("up_tick1", 16'h5959, 1, 0, 0, 0);
        tick = 1'b1; step();
        chk60("up_wrap_ovf", 16'h0000, 1, 1, 0, 0);
        tick = 1'b1; step();
        chk60("up_after_wrap", 16'h0001, 1, 0, 0, 0);
        mode_down = 1'b1; tick = 1'b1; step();
        chk60("mode_flip_down_done", 16'h0000, 0, 0, 1, 0);
        clear = 1'b1; step();
        chk60("clear_from_done", 16'h0000, 0, 0, 0, 0);
    endtask

    task automatic test_down_done();
        mode_down = 1'b1;
        do_load(16'h0100);
        start_stop = 1'b1; step();
        tick = 1'b1; step();
        chk60("down_borrow", 16'h0059, 1, 0, 0, 0);
        start_stop = 1'b1; step();
        chk60("down_pause", 16'h0059, 0, 0, 0, 0);
        do_load(16'h0001);
        start_stop = 1'b1; step();
        tick = 1'b1; step();
        chk60("down_done_pulse", 16'h0000, 0, 0, 1, 0);
        step();
        chk60("down_alarm_on", 16'h0000, 0, 0, 0, 1);
        for (int i = 0; i < 2; i++) begin
            tick = 1'b1; step();
            chk60("done_ticks_hold", 16'h0000, 0, 0, 0, 1);
        end
        start_stop = 1'b1; step();
        chk60("done_exit_idle", 16'h0000, 0, 0, 0, 0);
    endtask

    task automatic test_start_rules();
        clear = 1'b1; step();
        mode_down = 1'b1; start_stop = 1'b1; step();
        chk60("down_start_at_zero_ignored", 16'h0000, 0, 0, 0, 0);
        mode_down = 1'b0;
        do_load(16'h0005);
        start_stop = 1'b1; tick = 1'b1; step();
        chk60("start_and_tick_drops_tick", 16'h0005, 1, 0, 0, 0);
        tick = 1'b1; step();
        chk60("tick_after_start", 16'h0006, 1, 0, 0, 0);
    endtask

    task automatic test_pause_adjust();
        clear = 1'b1; step();
        mode_down = 1'b0;
        do_load(16'h0030);
        start_stop = 1'b1; step();
        start_stop = 1'b1; step();
        chk60("pause_entered", 16'h0030, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin tick = 1'b1; step(); end
        chk60("pause_ticks_ignored", 16'h0030, 0, 0, 0, 0);
        do_load(16'h1259);
        adj_sel = 1'b0; adj_inc = 1'b1; step();
        chk60("adj_lo_inc_wrap", 16'h1200, 0, 0, 0, 0);
        adj_inc = 1'b1; adj_dec = 1'b1; step();
        chk60("adj_inc_dec_same", 16'h1200, 0, 0, 0, 0);
        adj_dec = 1'b1; step();
        chk60("adj_lo_dec_wrap", 16'h1259, 0, 0, 0, 0);
        do_load(16'h0010);
        adj_sel = 1'b1; adj_dec = 1'b1; step();
        chk60("adj_hi_dec_wrap", 16'h5910, 0, 0, 0, 0);
        start_stop = 1'b1; step();
        adj_inc = 1'b1; step();
        chk60("adj_ignored_in_run", 16'h5910, 1, 0, 0, 0);
        adj_sel = 1'b0;
    endtask

    task automatic test_mod100_clamp();
        clear = 1'b1; step();
        mode_down = 1'b0;
        do_load(16'h9999);
        start_stop = 1'b1; step();
        tick = 1'b1; step();
        n_checks++;
        if ({bcd100, run100, ovf100} !== {16'h0000, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL mod100_wrap: got bcd=%h run=%b ovf=%b, expected bcd=0000 run=1 ovf=1", bcd100, run100, ovf100);
        end
        do_load(16'h1234);
        n_checks++;
        if (bcd100 !== 16'h0000) begin
            n_fail++;
            $display("FAIL load_in_run_ignored: got bcd=%h, expected 0000", bcd100);
        end
        start_stop = 1'b1; step();
        do_load(16'h7A3C);
        n_checks++;
        if (bcd100 !== 16'h9999) begin
            n_fail++;
            $display("FAIL mod100_clamp: got bcd=%h, expected 9999", bcd100);
        end
        chk60("mod60_clamp", 16'h5959, 0, 0, 0, 0);
    endtask

    task automatic test_async_reset();
        clear = 1'b1; step();
        mode_down = 1'b0;
        do_load(16'h1234);
        start_stop = 1'b1; step();
        chk60("pre_reset_run", 16'h1234, 1, 0, 0, 0);
        #2 reset_p = 1'b1;
        #1 chk60("async_reset_mid_run", 16'h0000, 0, 0, 0, 0);
        #1 reset_p = 1'b0;
        tick = 1'b1; step();
        chk60("idle_after_reset", 16'h0000, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_done();
        test_start_rules();
        test_pause_adjust();
        test_mod100_clamp();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
